// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes, ALU codes,
// mux selects, and the per-state Moore control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_FETCH = '{adr_src: 1'b0, mem_write: 1'b0, reg_write: 1'b0,
                                   result_src: RES_ALURES, src_a: SRCA_PC,
                                   src_b: SRCB_FOUR, aluop: ALUOP_ADD};

  // Moore control word; fields a state does not use stay at zero / add.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    unique case (s)
      S_FETCH:    c = CTRL_FETCH;
      S_DECODE:   begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_IMM; end
      S_MEMADR:   begin c.src_a = SRCA_RS1;   c.src_b = SRCB_IMM; end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECR:    begin c.src_a = SRCA_RS1; c.src_b = SRCB_RS2; c.aluop = ALUOP_FN; end
      S_EXECI:    begin c.src_a = SRCA_RS1; c.src_b = SRCB_IMM; c.aluop = ALUOP_FN; end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BRANCH:   begin c.src_a = SRCA_RS1; c.src_b = SRCB_RS2; c.aluop = ALUOP_SUB; end
      S_JAL:      begin c.src_a = SRCA_OLDPC; c.src_b = SRCB_FOUR; end
      default:    c = CTRL_FETCH;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control strobes out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero, notZero, LessThan, GreaterEqual;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  modport ctrl (
    input  op, funct3, funct7b5, Zero, notZero, LessThan, GreaterEqual, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, illegal
  );

  modport dp (
    output op, funct3, funct7b5, Zero, notZero, LessThan, GreaterEqual, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// ALU operation decode from aluop class and instruction function fields.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);
  always_comb begin
    alu_control = ALU_ADD;
    unique case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        unique case (funct3)
          // op[5] separates R-type from immediates, so addi never subtracts
          3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch, decode, memory access and writeback
// over a shared ALU and memory port.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  multicycle_controller_if.ctrl bus
);
  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   op_ok, taken;

  always_comb begin
    unique case (bus.op)
      OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL: op_ok = 1'b1;
      default:                                op_ok = 1'b0;
    endcase
  end

  always_comb begin
    unique case (bus.funct3)
      3'b000:  taken = bus.Zero;
      3'b001:  taken = bus.notZero;
      3'b100:  taken = bus.LessThan;
      3'b101:  taken = bus.GreaterEqual;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_B:         state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
    // Control word is precomputed for the state being entered so it is a flop output.
    ctrl_d = state_ctrl(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= CTRL_FETCH;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  alu_decoder u_alu_dec (
    .aluop       (ctrl_q.aluop),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (bus.ALUControl)
  );

  always_comb begin
    unique case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_B:    bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  // mem_ready and branch-outcome strobes are combinational; reset masks them
  // so nothing fires while the FSM is held in FETCH.
  assign bus.IRWrite   = reset && (state_q == S_FETCH) && bus.mem_ready;
  assign bus.PCWrite   = reset && (((state_q == S_FETCH) && bus.mem_ready) ||
                                   (state_q == S_JAL) ||
                                   ((state_q == S_BRANCH) && taken));
  assign bus.illegal   = reset && (state_q == S_DECODE) && !op_ok;
  assign bus.AdrSrc    = ctrl_q.adr_src;
  assign bus.MemWrite  = ctrl_q.mem_write;
  assign bus.RegWrite  = ctrl_q.reg_write;
  assign bus.ResultSrc = ctrl_q.result_src;
  assign bus.ALUSrcA   = ctrl_q.src_a;
  assign bus.ALUSrcB   = ctrl_q.src_b;
endmodule
